// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: fetch-stage bus between instruction memory, decode/ALU and the fetch unit.
interface instr_fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        instr_accept_i;
  logic        stall_i;
  logic        sig_branch_i;
  logic [15:0] immediate_i;
  logic        jump_i;
  logic [25:0] jump_target_i;
  logic [31:0] pc_out_o;
  logic [31:0] pc_plus4_o;
  logic [31:0] retire_count_o;
  modport master (
    output imem_req_o, imem_addr_o, instr_o, instr_valid_o, pc_out_o, pc_plus4_o, retire_count_o,
    input  imem_ready_i, imem_rdata_i, instr_accept_i, stall_i, sig_branch_i, immediate_i,
           jump_i, jump_target_i
  );
  modport slave (
    input  imem_req_o, imem_addr_o, instr_o, instr_valid_o, pc_out_o, pc_plus4_o, retire_count_o,
    output imem_ready_i, imem_rdata_i, instr_accept_i, stall_i, sig_branch_i, immediate_i,
           jump_i, jump_target_i
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC register, req/ready instruction fetch, next-PC selection and retire counter.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic              clk,
  input logic              rst,
  instr_fetch_unit_if.master bus
);
  localparam logic [1:0] S_BOOT = 2'd0, S_FETCH = 2'd1, S_HOLD = 2'd2;
  localparam logic [31:0] PC_RST = {RESET_PC[31:2], 2'b00};
  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, ret_q, ret_d, pc_plus4, br_off, next_pc;
  logic        fetch_done, accept;
  always_comb begin
    pc_plus4   = pc_q + 32'd4;
    br_off     = {{14{bus.immediate_i[15]}}, bus.immediate_i, 2'b00};
    fetch_done = (state_q == S_FETCH) && bus.imem_ready_i;
    accept     = (state_q == S_HOLD) && bus.instr_accept_i && !bus.stall_i;
    next_pc    = bus.jump_i       ? {pc_plus4[31:28], bus.jump_target_i, 2'b00} :
                 bus.sig_branch_i ? pc_plus4 + br_off : pc_plus4;
    pc_d       = accept ? next_pc : pc_q;
    instr_d    = fetch_done ? bus.imem_rdata_i : instr_q;
    ret_d      = accept ? ret_q + 32'd1 : ret_q;
    state_d    = (state_q == S_BOOT) ? S_FETCH :
                 fetch_done          ? S_HOLD  :
                 accept              ? S_FETCH : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= PC_RST;
      instr_q <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ret_q   <= ret_d;
    end
  end
  assign bus.imem_req_o     = (state_q == S_FETCH);
  assign bus.imem_addr_o    = pc_q;
  assign bus.instr_o        = instr_q;
  assign bus.instr_valid_o  = (state_q == S_HOLD);
  assign bus.pc_out_o       = pc_q;
  assign bus.pc_plus4_o     = pc_plus4;
  assign bus.retire_count_o = ret_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed literal checks plus randomized traffic against a transaction-level model.
module tb_instr_fetch_unit;
  localparam logic [31:0] RP = 32'h0000_0003;
  logic clk = 1'b0, rst;
  int total = 0, bad = 0;
  instr_fetch_unit_if bus ();
  instr_fetch_unit #(.RESET_PC(RP)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  // model: a word is either being requested, held for decode, or we are in the boot gap
  logic [31:0] m_pc, m_instr, m_ret;
  logic        m_valid, m_boot, chk_en = 1'b0;
  wire         m_req = !m_boot && !m_valid;
  wire  [31:0] m_p4  = m_pc + 32'd4;

  function automatic logic [31:0] m_next();
    if (bus.jump_i) return {m_p4[31:28], bus.jump_target_i, 2'b00};
    if (bus.sig_branch_i) return m_p4 + 32'($signed(bus.immediate_i)) * 32'd4;
    return m_p4;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pc <= RP & ~32'd3;
      m_instr <= '0;
      m_valid <= 1'b0;
      m_boot <= 1'b1;
      m_ret <= '0;
      chk_en <= 1'b1;
    end else if (m_boot) m_boot <= 1'b0;
    else if (!m_valid) begin
      if (bus.imem_ready_i) begin
        m_instr <= bus.imem_rdata_i;
        m_valid <= 1'b1;
      end
    end else if (bus.instr_accept_i && !bus.stall_i) begin
      m_pc <= m_next();
      m_valid <= 1'b0;
      m_ret <= m_ret + 32'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    check("req", 32'(bus.imem_req_o), 32'(m_req));
    check("addr", bus.imem_addr_o, m_pc);
    check("instr", bus.instr_o, m_instr);
    check("valid", 32'(bus.instr_valid_o), 32'(m_valid));
    check("pc", bus.pc_out_o, m_pc);
    check("pc4", bus.pc_plus4_o, m_p4);
    check("retire", bus.retire_count_o, m_ret);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic fetch_accept(input logic [31:0] w, input logic br, input logic jp,
                              input logic [15:0] imm, input logic [25:0] jt);
    bus.imem_ready_i = 1'b1;
    bus.imem_rdata_i = w;
    tick();
    bus.imem_ready_i = 1'b0;
    bus.instr_accept_i = 1'b1;
    bus.sig_branch_i = br;
    bus.jump_i = jp;
    bus.immediate_i = imm;
    bus.jump_target_i = jt;
    tick();
    bus.instr_accept_i = 1'b0;
    bus.sig_branch_i = 1'b0;
    bus.jump_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.imem_ready_i = 1'b0;
    bus.imem_rdata_i = '0;
    bus.instr_accept_i = 1'b0;
    bus.stall_i = 1'b0;
    bus.sig_branch_i = 1'b0;
    bus.immediate_i = '0;
    bus.jump_i = 1'b0;
    bus.jump_target_i = '0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    check("boot_req", 32'(bus.imem_req_o), 32'd0);
    check("boot_valid", 32'(bus.instr_valid_o), 32'd0);
    check("boot_ret", bus.retire_count_o, 32'd0);
    tick();
    check("first_req", 32'(bus.imem_req_o), 32'd1);
    check("first_addr", bus.imem_addr_o, 32'd0);
    bus.imem_ready_i = 1'b1;
    bus.imem_rdata_i = 32'h2002_0005;
    tick();
    bus.imem_ready_i = 1'b0;
    check("t2_valid", 32'(bus.instr_valid_o), 32'd1);
    check("t2_instr", bus.instr_o, 32'h2002_0005);
    bus.instr_accept_i = 1'b1;
    tick();
    bus.instr_accept_i = 1'b0;
    check("t2_addr", bus.imem_addr_o, 32'd4);
    check("t2_ret", bus.retire_count_o, 32'd1);
    fetch_accept(32'h1111_0000, 1'b0, 1'b1, 16'h0, 26'h10);
    check("to40", bus.imem_addr_o, 32'h40);
    fetch_accept(32'h1111_0001, 1'b1, 1'b0, 16'hFFFE, 26'h0);
    check("br_neg", bus.imem_addr_o, 32'h3C);
    fetch_accept(32'h1111_0002, 1'b0, 1'b1, 16'h0, 26'h10);
    fetch_accept(32'h1111_0003, 1'b1, 1'b0, 16'h0003, 26'h0);
    check("br_pos", bus.imem_addr_o, 32'h50);
    fetch_accept(32'h1111_0004, 1'b0, 1'b1, 16'h0, 26'h10);
    fetch_accept(32'h1111_0005, 1'b1, 1'b1, 16'h0003, 26'h100);
    check("jump_wins", bus.imem_addr_o, 32'h400);
    repeat (3) begin
      tick();
      check("wait_req", 32'(bus.imem_req_o), 32'd1);
      check("wait_addr", bus.imem_addr_o, 32'h400);
    end
    bus.imem_ready_i = 1'b1;
    bus.imem_rdata_i = 32'hCAFE_0007;
    tick();
    bus.imem_ready_i = 1'b0;
    bus.stall_i = 1'b1;
    bus.instr_accept_i = 1'b1;
    repeat (4) begin
      tick();
      check("stall_valid", 32'(bus.instr_valid_o), 32'd1);
      check("stall_pc", bus.pc_out_o, 32'h400);
      check("stall_instr", bus.instr_o, 32'hCAFE_0007);
      check("stall_ret", bus.retire_count_o, 32'd7);
    end
    bus.stall_i = 1'b0;
    tick();
    bus.instr_accept_i = 1'b0;
    check("unstall_addr", bus.imem_addr_o, 32'h404);
    check("unstall_ret", bus.retire_count_o, 32'd8);
    rst = 1'b1;
    bus.imem_ready_i = 1'b1;
    bus.imem_rdata_i = 32'hDEAD_BEEF;
    tick();
    rst = 1'b0;
    check("rst_valid", 32'(bus.instr_valid_o), 32'd0);
    check("rst_pc", bus.pc_out_o, 32'd0);
    check("rst_ret", bus.retire_count_o, 32'd0);
    check("rst_req", 32'(bus.imem_req_o), 32'd0);
    tick();
    bus.imem_ready_i = 1'b0;
    check("late_valid", 32'(bus.instr_valid_o), 32'd0);
    check("restart_req", 32'(bus.imem_req_o), 32'd1);
    check("restart_addr", bus.imem_addr_o, 32'd0);
    fetch_accept(32'h2222_0000, 1'b1, 1'b0, 16'hFFFE, 26'h0);
    check("wrap_neg", bus.imem_addr_o, 32'hFFFF_FFFC);
    check("wrap_p4", bus.pc_plus4_o, 32'd0);
    fetch_accept(32'h2222_0001, 1'b0, 1'b0, 16'h0, 26'h0);
    check("wrap_pos", bus.imem_addr_o, 32'd0);
    repeat (4000) begin
      rst = ($urandom_range(99) == 0);
      bus.imem_ready_i = $urandom_range(1);
      bus.imem_rdata_i = $urandom;
      bus.instr_accept_i = $urandom_range(1);
      bus.stall_i = ($urandom_range(9) < 3);
      bus.sig_branch_i = $urandom_range(1);
      bus.jump_i = ($urandom_range(3) == 0);
      bus.immediate_i = 16'($urandom);
      bus.jump_target_i = 26'($urandom);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
